sld_stream_ctrl: RTL

//   Sequences the distributed-RAM scene (SLD) byte table into the core's input path.

---
 rtl/sld_stream_ctrl_if.sv | 29 ++
 rtl/sld_stream_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/sld_stream_ctrl_if.sv
// Stream bundle between sld_stream_ctrl and its neighbours: the scene table
// read port (address out, same-cycle data back) and the valid/ready byte
// stream towards the core's "in" instruction.
interface sld_stream_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output rom_addr,
    input  rom_data,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/sld_stream_ctrl.sv
// sld_stream_ctrl: walks scene table addresses 0..LEN-1, prefetches bytes
// into a small FIFO and hands them to the core over valid/ready.
// This block is the only driver of the table address.
// Optional feature macro: SLD_CHECKSUM_EN adds a 16-bit running sum of all
// popped bytes on port checksum; without it the port and adder are absent.
module sld_stream_ctrl #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 8,
  parameter int LEN        = 1501,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              rewind,
  sld_stream_ctrl_if.master bus,
  output logic              done,
  output logic [ADDR_W-1:0] consumed
`ifdef SLD_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [ADDR_W-1:0] LEN_A = ADDR_W'(LEN);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] fetch_ptr_q, fetch_ptr_d;
  logic [ADDR_W-1:0] consumed_q, consumed_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];

  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push;
  logic start_acc;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                      (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);

  // rewind overrides every other action in its cycle, so it masks pop/push/start.
  assign pop       = !fifo_empty && bus.out_ready && !rewind;
  assign push      = (state_q == ST_FILL) && (fetch_ptr_q != LEN_A) &&
                     (!fifo_full || pop) && !rewind;
  assign start_acc = start && (state_q == ST_IDLE) && !rewind;

  assign bus.rom_addr  = fetch_ptr_q;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_empty ? '0 : mem_q[rd_ptr_q[IDX_W-1:0]];
  assign done          = (state_q == ST_DONE);
  assign consumed      = consumed_q;

  // Next-state for the sequencer, fetch pointer, FIFO pointers and pop counter.
  always_comb begin
    state_d     = state_q;
    fetch_ptr_d = fetch_ptr_q;
    consumed_d  = consumed_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (rewind) begin
      state_d     = ST_FILL;
      fetch_ptr_d = '0;
      consumed_d  = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d    = wr_ptr_q + 1'b1;
        fetch_ptr_d = fetch_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d   = rd_ptr_q + 1'b1;
        consumed_d = consumed_q + 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (start_acc) begin
            state_d     = ST_FILL;
            fetch_ptr_d = '0;
            consumed_d  = '0;
          end
        end
        ST_FILL:  if (fetch_ptr_q == LEN_A) state_d = ST_DRAIN;
        ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
        default:  state_d = state_q;
      endcase
    end
  end

  // Control state registers; reset discards all streaming progress.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      fetch_ptr_q <= '0;
      consumed_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      fetch_ptr_q <= fetch_ptr_d;
      consumed_q  <= consumed_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // FIFO storage write; no bypass, a pushed byte is readable from the next cycle.
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q[IDX_W-1:0]] = bus.rom_data;
  end

  // FIFO storage holds data only; occupancy lives in the pointers, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef SLD_CHECKSUM_EN
  logic [15:0] checksum_q, checksum_d;

  // Running 16-bit sum of popped bytes, restarted whenever streaming restarts.
  always_comb begin
    checksum_d = checksum_q;
    if (rewind || start_acc) checksum_d = '0;
    else if (pop)            checksum_d = checksum_q + 16'(bus.out_data);
  end

  // Checksum register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) checksum_q <= '0;
    else       checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`endif

endmodule
